// File: rtl/fir_sample_capture.sv
// Frame capture buffer for the 3-tap FIR output: arms on start, stores
// FRAME_LEN samples, then drains them over a valid/ready stream.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            one-cycle arm request, honoured only while idle
//   s_data, s_valid  signed FIR output sample and its qualifier
//   m_data, m_valid  drained sample and its qualifier
//   m_ready          consumer accepts m_data
//   m_last           final sample of the frame (qualified by m_valid)
//   busy             high while capturing or draining
//   done             one-cycle pulse after the final drain handshake
//
// Optional build macro FIR_CAPTURE_DECIM_EN: keep only one of every
// DECIM valid input samples while capturing.

module fir_sample_capture #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 64,
  parameter int DECIM     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FRAME_LEN);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_LEN - 1);

  if (FRAME_LEN < 2 || DECIM < 1) begin : g_param_check
    $error("fir_sample_capture: FRAME_LEN must be >=2, DECIM >=1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [FRAME_LEN];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              fetched_q, fetched_d;
  logic [DATA_W-1:0] pre_data_q, pre_data_d;
  logic              pre_valid_q, pre_valid_d;
  logic              pre_last_q, pre_last_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              done_q, done_d;

  logic keep;
  logic wr_en;
  logic hs;
  logic out_load;
  logic fetch;

`ifdef FIR_CAPTURE_DECIM_EN
  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

  logic [PH_W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (state_q == S_IDLE && start) begin
      phase_d = '0;
    end else if (state_q == S_CAPTURE && s_valid) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) phase_q <= '0;
    else     phase_q <= phase_d;
  end

  assign keep = (phase_q == '0);
`else
  assign keep = 1'b1;
`endif

  assign wr_en = (state_q == S_CAPTURE) && s_valid && keep;
  assign hs    = m_valid_q && m_ready;

  // Two-stage drain: prefetch register behind the output register, so
  // the registered buffer read never inserts a bubble under m_ready=1.
  assign out_load = pre_valid_q && (!m_valid_q || hs);
  assign fetch    = (state_q == S_DRAIN) && !fetched_q &&
                    (!pre_valid_q || out_load);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_CAPTURE;
      S_CAPTURE: if (wr_en && wr_ptr_q == LAST_IDX) state_d = S_DRAIN;
      S_DRAIN:   if (hs && m_last_q) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy    = (state_q != S_IDLE);
    m_data  = m_data_q;
    m_valid = m_valid_q;
    m_last  = m_last_q;
    done    = done_q;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fetched_d   = fetched_q;
    pre_data_d  = pre_data_q;
    pre_valid_d = pre_valid_q;
    pre_last_d  = pre_last_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    done_d      = hs && m_last_q;

    if (state_q == S_IDLE && start) begin
      wr_ptr_d = '0;
    end

    if (wr_en) begin
      if (wr_ptr_q == LAST_IDX) begin
        rd_ptr_d    = '0;
        fetched_d   = 1'b0;
        pre_valid_d = 1'b0;
      end else begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
    end

    if (fetch) begin
      pre_data_d  = mem[rd_ptr_q];
      pre_valid_d = 1'b1;
      pre_last_d  = (rd_ptr_q == LAST_IDX);
      if (rd_ptr_q == LAST_IDX) fetched_d = 1'b1;
      else                      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
    end else if (out_load) begin
      pre_valid_d = 1'b0;
    end

    if (out_load) begin
      m_data_d  = pre_data_q;
      m_valid_d = 1'b1;
      m_last_d  = pre_last_q;
    end else if (hs) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fetched_q   <= 1'b0;
      pre_data_q  <= '0;
      pre_valid_q <= 1'b0;
      pre_last_q  <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fetched_q   <= fetched_d;
      pre_data_q  <= pre_data_d;
      pre_valid_q <= pre_valid_d;
      pre_last_q  <= pre_last_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      done_q      <= done_d;
    end
  end

  // Buffer storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr_q] <= s_data;
  end

endmodule

// File: tb/tb_fir_sample_capture.sv
// Bench for fir_sample_capture: directed frames checked against a
// queue model of the captured samples, plus literal spot values.

module tb_fir_sample_capture;

  localparam int DW  = 16;
  localparam int N   = 8;
  localparam int DEC = 4;
`ifdef FIR_CAPTURE_DECIM_EN
  localparam int MDEC = DEC;
`else
  localparam int MDEC = 1;
`endif

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic          done;

  fir_sample_capture #(
    .DATA_W   (DW),
    .FRAME_LEN(N),
    .DECIM    (DEC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .s_data (s_data),
    .s_valid(s_valid),
    .m_data (m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last (m_last),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Model state: what the frame must contain and what was drained.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_q[$];
  int idx;
  int lw;
  bit seen_valid;
  bit done_pend;
  bit frame_done;
  bit mon_en = 1'b0;
  int ready_mode = 0;
  int rc = 0;

  // Consumer: always ready, or the repeating pattern 1,0,0.
  always @(posedge clk) begin
    #1;
    rc++;
    if (ready_mode == 0) m_ready = 1'b1;
    else                 m_ready = (rc % 3 == 0);
  end

  // Compare process, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("done", done, done_pend);
      if (done && done_pend) frame_done = 1'b1;
      done_pend = 1'b0;
      if (m_valid) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          chk("valid_rise_cycle", cyc, lw + 2);
        end
        if (idx < exp_q.size())
          chk("m_data", int'(m_data), int'(exp_q[idx]));
        else
          chk("m_valid_extra", 1, 0);
        chk("m_last", m_last, int'(idx == N - 1));
        if (m_ready) begin
          obs_q.push_back(m_data);
          if (idx == N - 1) done_pend = 1'b1;
          idx++;
        end
      end
    end
  end

  // Arms a frame, feeds ramp base+k on valid cycles, waits for the drain.
  task automatic run_frame(input logic [DW-1:0] base, input bit gapped,
                           input int rmode, input int abort_at);
    int k;
    int kept;
    int c;
    ready_mode = rmode;
    exp_q.delete();
    obs_q.delete();
    idx        = 0;
    seen_valid = 1'b0;
    done_pend  = 1'b0;
    frame_done = 1'b0;
    lw         = -1000;
    mon_en     = 1'b1;
    start   = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'h7777;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    k = 0; kept = 0; c = 0;
    while (kept < N) begin
      if (!gapped || c % 2 == 0) begin
        s_valid = 1'b1;
        s_data  = base + DW'(k);
        if (k % MDEC == 0) begin
          exp_q.push_back(s_data);
          kept++;
          if (kept == N) lw = cyc + 1;
        end
        k++;
      end else begin
        s_valid = 1'b0;
        s_data  = 16'hDEAD;
      end
      c++;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = 16'h5555;
    for (int t = 0; t < 300 && !frame_done; t++) begin
      if (abort_at > 0 && obs_q.size() == abort_at) break;
      @(posedge clk); #1;
    end
    if (abort_at > 0) begin
      rst    = 1'b1;
      mon_en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_m_valid", m_valid, 0);
      chk("abort_m_last", m_last, 0);
      chk("abort_m_data", int'(m_data), 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_drained", obs_q.size(), abort_at);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
      @(posedge clk); #1;
    end else begin
      if (!frame_done) chk("frame_timeout", 0, 1);
      @(negedge clk);
      chk("busy_end", busy, 0);
      chk("m_valid_end", m_valid, 0);
      chk("drained_count", obs_q.size(), N);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    s_valid    = 1'b1;
    s_data     = 16'h1111;
    m_ready    = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_m_last", m_last, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_m_valid", m_valid, 0);
    end
    @(posedge clk); #1;

    // Basic ramp 100..107, always ready.
    run_frame(16'd100, 1'b0, 0, 0);
    chk("basic_first", int'(obs_q[0]), 100);
    chk("basic_last", int'(obs_q[N-1]), 100 + 7 * MDEC);

    // Backpressure 1,0,0,...
    run_frame(16'd100, 1'b0, 1, 0);
    chk("bp_first", int'(obs_q[0]), 100);
    chk("bp_last", int'(obs_q[N-1]), 100 + 7 * MDEC);

    // Negative ramp from -5, sign preserved.
    run_frame(16'hFFFB, 1'b0, 1, 0);
    chk("neg_first", int'(obs_q[0]), 16'hFFFB);
    chk("neg_last", int'(obs_q[N-1]), (7 * MDEC - 5) & 16'hFFFF);

    // Gapped input.
    run_frame(16'd300, 1'b1, 0, 0);
    chk("gap_last", int'(obs_q[N-1]), 300 + 7 * MDEC);

    // Abort after the fourth drained sample, then a fresh frame.
    run_frame(16'd50, 1'b0, 0, 4);
    run_frame(16'd200, 1'b0, 0, 0);
    chk("fresh_first", int'(obs_q[0]), 200);

    // Continuous 0.. : decimated 0,4,..,28 or plain 0..7.
    run_frame(16'd0, 1'b0, 0, 0);
    chk("dec_second", int'(obs_q[1]), MDEC);
    chk("dec_last", int'(obs_q[N-1]), 7 * MDEC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
